hold_time_meter: RTL and testbench
==================================

# hold_time_meter

Measures the width of the high-voltage hold pulse in whole seconds. It rounds the result to the nearest second, reports it with a one-cycle strobe, and compares it against the programmed hold delay. It sits on the receiving end of the hold-pulse generator's output and confirms that the HV hold actually lasted the requested time, flagging any mismatch or overrun to the frame-registration control logic.

## Interface
- TICKS_PER_SEC, 100000000: clk_Delay cycles per second; minimum 4, must be even.
- FILT_LEN, 4: stable samples required by the glitch filter; used only with the filter macro.
- clk_Delay  input  1  system clock, 100 MHz.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- hold_in  input  1  HV hold pulse being measured; asynchronous to clk_Delay.
- expected  input  8  programmed hold time in seconds; sampled on the rising edge of hold_in.
- meas_sec  output  8  last measured width, rounded to seconds; holds its value until the next report.
- meas_valid  output  1  one-cycle strobe; meas_sec, mismatch and overflow are updated in the same cycle.
- busy  output  1  high while a pulse is being measured.
- mismatch  output  1  meas_sec ≠ latched expected; updated with meas_valid.
- overflow  output  1  width exceeded 255 s; sticky until the next rising edge of hold_in.

## Operation
- Input path: two-flop synchronizer, then one register for edge detection. rise = s & ~s_d, fall = ~s & s_d.
- States and transitions:
  - IDLE → COUNT on rise.
  - COUNT → REPORT on fall.
  - REPORT → COUNT if rise occurs in the same cycle, otherwise REPORT → IDLE.
  - REPORT lasts exactly one cycle.
- On entering COUNT:
  - tick ← 0, sec ← 0.
  - exp_q ← expected.
  - overflow ← 0.
- Counting in COUNT:
  - tick counts 0..TICKS_PER_SEC-1 and is $clog2(TICKS_PER_SEC) bits wide.
  - When tick wraps to 0, sec increments.
  - sec saturates at 255. An increment attempted at 255 sets overflow.
- Rounding in REPORT:
  - meas_sec = sec + (tick ≥ TICKS_PER_SEC/2), saturated at 255.
  - mismatch = (meas_sec ≠ exp_q) | overflow.
- A pulse already high when rst_n is released is not measured. A rising edge is required.
- A pulse shorter than TICKS_PER_SEC/2 cycles reports meas_sec = 0. With expected = 0 this is not a mismatch.
- A change on the expected input during COUNT has no effect; only exp_q is used.
- Reset in mid-measurement aborts it:
  - No meas_valid is produced.
  - All state clears on the next edge with rst_n low.

## Timing
- Values on reset: meas_sec = 0, meas_valid = 0, busy = 0, mismatch = 0, overflow = 0; state = IDLE.
- Synchronizer plus edge detect: rise/fall is seen 3 cycles after the hold_in transition (4 cycles after the transition if it arrives just after the sampling edge).
- busy rises 1 cycle after rise is seen, and falls in the REPORT cycle.
- Width counted equals the input width ±1 cycle, because the rising and falling paths have identical latency.
- meas_valid is asserted 1 cycle after fall is seen.
- Back-to-back pulses separated by at least 1 low cycle at the synchronizer output are each measured; no pulse is lost.

## Configuration
- HOLD_METER_GLITCH_FILTER_EN defined:
  - s changes only after the synchronized input has held the new level for FILT_LEN consecutive cycles.
  - Pulses or gaps shorter than FILT_LEN cycles are ignored.
  - Edge latency grows by FILT_LEN cycles.
- HOLD_METER_GLITCH_FILTER_EN undefined:
  - s = synchronizer output directly.
  - FILT_LEN is unused.

## Structure
- Package hold_meter_pkg holds:
  - the state enum (IDLE, COUNT, REPORT);
  - SEC_W = 8;
  - SEC_MAX = 8'd255.
- One sub-module, hold_in_conditioner, contains the synchronizer, the optional glitch filter and the edge detect, and outputs rise and fall.
- Top level contains the FSM, the tick/sec counters and the result registers.

## Test plan
- TICKS_PER_SEC = 10 for all scenarios.
- Pulse of 30 cycles, expected = 3 → meas_valid once; meas_sec = 3, mismatch = 0, overflow = 0.
- Pulse of 34 cycles, expected = 3 → meas_sec = 3. Pulse of 35 cycles, expected = 3 → meas_sec = 4, mismatch = 1.
- Pulse of 4 cycles, expected = 0 → meas_sec = 0, mismatch = 0.
- Pulse of 2600 cycles → meas_sec = 255, overflow = 1, mismatch = 1. The next rise clears overflow.
- hold_in high at reset release, then falling → no meas_valid. rst_n low for 1 cycle in the middle of a pulse → busy = 0, no meas_valid, outputs at reset values.
- With filter enabled (FILT_LEN = 4): 3-cycle glitch → busy never asserts. With filter disabled: the same glitch → meas_valid with meas_sec = 0.

Source files
------------

// File: rtl/hold_meter_pkg.sv
// Shared state encoding, second-counter width and saturating increment for the hold-pulse meter.
// Pure types/constants package; no logic, no latency, no flow control.
package hold_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REPORT
  } state_t;

  localparam int SEC_W = 8;
  localparam logic [SEC_W-1:0] SEC_MAX = 8'd255;

  function automatic logic [SEC_W-1:0] sat_inc(input logic [SEC_W-1:0] v, input logic inc);
    return (inc && (v != SEC_MAX)) ? v + SEC_W'(1) : v;
  endfunction

endpackage

// File: rtl/hold_time_meter_conditioner.sv
// hold_in_conditioner: 2-flop sync, optional HOLD_METER_GLITCH_FILTER_EN filter, edge detect.
// Edge pulses 2 clocks after the sampled transition (+FILT_LEN when filtered); no backpressure.
module hold_in_conditioner import hold_meter_pkg::*; #(
  parameter int FILT_LEN = 4
) (
  input  logic clk_Delay,
  input  logic rst_n,
  input  logic hold_in,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic s;
  logic s_d;

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("FILT_LEN must be at least 1");
  end

  // Synchronizer flops only track the pin, so they are left out of reset.
  always_ff @(posedge clk_Delay) begin
    sync1 <= hold_in;
    sync2 <= sync1;
  end

`ifdef HOLD_METER_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_Delay) begin
    if (!rst_n) begin
      s   <= 1'b1;
      cnt <= '0;
    end else if (sync2 == s) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
      s   <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign s = sync2;
`endif

  // Resetting the history high means a level already high at reset release never yields a rise.
  always_ff @(posedge clk_Delay) begin
    if (!rst_n) s_d <= 1'b1;
    else        s_d <= s;
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/hold_time_meter.sv
// Measures HV hold pulse width in rounded seconds and checks it against the latched expected value.
// Result strobes 1 clock after fall is seen; no backpressure. Optional filter: HOLD_METER_GLITCH_FILTER_EN.
module hold_time_meter import hold_meter_pkg::*; #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int FILT_LEN      = 4
) (
  input  logic             clk_Delay,
  input  logic             rst_n,
  input  logic             hold_in,
  input  logic [SEC_W-1:0] expected,
  output logic [SEC_W-1:0] meas_sec,
  output logic             meas_valid,
  output logic             busy,
  output logic             mismatch,
  output logic             overflow
);

  localparam int TICK_W = $clog2(TICKS_PER_SEC);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICKS_PER_SEC / 2);

  if ((TICKS_PER_SEC < 4) || ((TICKS_PER_SEC % 2) != 0)) begin : g_bad_ticks
    $error("TICKS_PER_SEC must be even and at least 4");
  end

  state_t state;
  state_t state_nx;
  logic rise;
  logic fall;
  logic start;
  logic wrap;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_nx;
  logic [SEC_W-1:0] sec;
  logic [SEC_W-1:0] sec_nx;
  logic [SEC_W-1:0] exp_q;
  logic [SEC_W-1:0] rounded;
  logic ovf_run;
  logic ovf_nx;

  hold_in_conditioner #(
    .FILT_LEN(FILT_LEN)
  ) u_cond (
    .clk_Delay(clk_Delay),
    .rst_n    (rst_n),
    .hold_in  (hold_in),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge clk_Delay) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      IDLE:    if (rise) state_nx = COUNT;
      COUNT: begin
        busy = 1'b1;
        if (fall) state_nx = REPORT;
      end
      REPORT:  state_nx = rise ? COUNT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result is formed from the counter values after the final (fall-cycle) increment.
  always_comb begin
    start   = (state_nx == COUNT) && (state != COUNT);
    wrap    = (tick == TICK_LAST);
    tick_nx = wrap ? '0 : tick + TICK_W'(1);
    sec_nx  = sat_inc(sec, wrap);
    ovf_nx  = ovf_run | (wrap && (sec == SEC_MAX));
    rounded = sat_inc(sec_nx, tick_nx >= TICK_HALF);
  end

  always_ff @(posedge clk_Delay) begin
    if (!rst_n) begin
      tick       <= '0;
      sec        <= '0;
      exp_q      <= '0;
      ovf_run    <= 1'b0;
      meas_sec   <= '0;
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (start) begin
        tick     <= '0;
        sec      <= '0;
        exp_q    <= expected;
        ovf_run  <= 1'b0;
        overflow <= 1'b0;
      end else if (state == COUNT) begin
        tick    <= tick_nx;
        sec     <= sec_nx;
        ovf_run <= ovf_nx;
        if (fall) begin
          meas_sec   <= rounded;
          mismatch   <= (rounded != exp_q) | ovf_nx;
          overflow   <= ovf_nx;
          meas_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hold_time_meter.sv
// Directed bench for hold_time_meter with TICKS_PER_SEC = 10; expected values are hand-computed.
module tb_hold_time_meter;

  localparam int T  = 10;
  localparam int FL = 4;
`ifdef HOLD_METER_GLITCH_FILTER_EN
  localparam int GAP = FL;
`else
  localparam int GAP = 1;
`endif

  logic       clk_Delay = 1'b0;
  logic       rst_n;
  logic       hold_in;
  logic [7:0] expected;
  logic [7:0] meas_sec;
  logic       meas_valid;
  logic       busy;
  logic       mismatch;
  logic       overflow;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int vcnt   = 0;
  bit busy_seen = 1'b0;
  logic [7:0] log_sec [$];
  logic       log_mis [$];
  logic       log_ovf [$];

  hold_time_meter #(
    .TICKS_PER_SEC(T),
    .FILT_LEN     (FL)
  ) dut (
    .clk_Delay (clk_Delay),
    .rst_n     (rst_n),
    .hold_in   (hold_in),
    .expected  (expected),
    .meas_sec  (meas_sec),
    .meas_valid(meas_valid),
    .busy      (busy),
    .mismatch  (mismatch),
    .overflow  (overflow)
  );

  always #5 clk_Delay = ~clk_Delay;

  always @(negedge clk_Delay) begin
    if (busy === 1'b1) busy_seen = 1'b1;
    if (meas_valid === 1'b1) begin
      vcnt++;
      log_sec.push_back(meas_sec);
      log_mis.push_back(mismatch);
      log_ovf.push_back(overflow);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // High for exactly `width` sampling edges; expected is scrambled mid-pulse to prove it is latched.
  task automatic pulse(input int width, input logic [7:0] e);
    @(posedge clk_Delay);
    #1;
    expected = e;
    hold_in  = 1'b1;
    for (int i = 1; i <= width; i++) begin
      @(posedge clk_Delay);
      if (i == 10) begin
        #1;
        expected = ~e;
      end
    end
    #1;
    hold_in = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget);
    for (int n = 0; n < budget && vcnt < target; n++) @(negedge clk_Delay);
    repeat (FL + 8) @(negedge clk_Delay);
  endtask

  initial begin
    int base;
    rst_n    = 1'b0;
    hold_in  = 1'b0;
    expected = 8'd0;
    repeat (3) @(posedge clk_Delay);
    @(negedge clk_Delay);
    check("rst_meas_sec", 32'(meas_sec), 0);
    check("rst_meas_valid", 32'(meas_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mismatch", 32'(mismatch), 0);
    check("rst_overflow", 32'(overflow), 0);
    @(posedge clk_Delay);
    #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk_Delay);

    base = vcnt;
    busy_seen = 1'b0;
    pulse(30, 8'd3);
    wait_valid(base + 1, 40);
    check("p30_count", vcnt - base, 1);
    check("p30_sec", 32'(log_sec[$]), 3);
    check("p30_mis", 32'(log_mis[$]), 0);
    check("p30_ovf", 32'(log_ovf[$]), 0);
    check("p30_busy_seen", 32'(busy_seen), 1);
    check("p30_busy_after", 32'(busy), 0);
    check("p30_sec_held", 32'(meas_sec), 3);

    base = vcnt;
    pulse(34, 8'd3);
    wait_valid(base + 1, 40);
    check("p34_count", vcnt - base, 1);
    check("p34_sec", 32'(log_sec[$]), 3);
    check("p34_mis", 32'(log_mis[$]), 0);

    base = vcnt;
    pulse(35, 8'd3);
    wait_valid(base + 1, 40);
    check("p35_count", vcnt - base, 1);
    check("p35_sec", 32'(log_sec[$]), 4);
    check("p35_mis", 32'(log_mis[$]), 1);

    base = vcnt;
    pulse(4, 8'd0);
    wait_valid(base + 1, 40);
    check("p4_count", vcnt - base, 1);
    check("p4_sec", 32'(log_sec[$]), 0);
    check("p4_mis", 32'(log_mis[$]), 0);

    base = vcnt;
    pulse(2600, 8'd200);
    wait_valid(base + 1, 40);
    check("p2600_count", vcnt - base, 1);
    check("p2600_sec", 32'(log_sec[$]), 255);
    check("p2600_ovf", 32'(log_ovf[$]), 1);
    check("p2600_mis", 32'(log_mis[$]), 1);
    repeat (5) @(negedge clk_Delay);
    check("ovf_sticky", 32'(overflow), 1);

    base = vcnt;
    @(posedge clk_Delay);
    #1;
    expected = 8'd2;
    hold_in  = 1'b1;
    repeat (12) @(posedge clk_Delay);
    @(negedge clk_Delay);
    check("ovf_clear_on_rise", 32'(overflow), 0);
    check("ovf_clear_busy", 32'(busy), 1);
    repeat (8) @(posedge clk_Delay);
    #1;
    hold_in = 1'b0;
    wait_valid(base + 1, 40);
    check("p20_count", vcnt - base, 1);
    check("p20_sec", 32'(log_sec[$]), 2);
    check("p20_mis", 32'(log_mis[$]), 0);

    base = vcnt;
    pulse(20, 8'd2);
    repeat (GAP - 1) @(posedge clk_Delay);
    pulse(30, 8'd3);
    wait_valid(base + 2, 60);
    check("b2b_count", vcnt - base, 2);
    check("b2b_first_sec", 32'(log_sec[$-1]), 2);
    check("b2b_second_sec", 32'(log_sec[$]), 3);
    check("b2b_first_mis", 32'(log_mis[$-1]), 0);
    check("b2b_second_mis", 32'(log_mis[$]), 0);

    base = vcnt;
    @(posedge clk_Delay);
    #1;
    expected = 8'd5;
    hold_in  = 1'b1;
    repeat (15) @(posedge clk_Delay);
    @(negedge clk_Delay);
    check("midrst_busy_before", 32'(busy), 1);
    @(posedge clk_Delay);
    #1;
    rst_n = 1'b0;
    @(posedge clk_Delay);
    #1;
    rst_n = 1'b1;
    @(negedge clk_Delay);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_meas_sec", 32'(meas_sec), 0);
    check("midrst_valid", 32'(meas_valid), 0);
    check("midrst_mismatch", 32'(mismatch), 0);
    check("midrst_overflow", 32'(overflow), 0);
    repeat (10) @(posedge clk_Delay);
    #1;
    hold_in = 1'b0;
    repeat (30) @(negedge clk_Delay);
    check("midrst_no_valid", vcnt - base, 0);

    base = vcnt;
    @(posedge clk_Delay);
    #1;
    hold_in = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk_Delay);
    #1;
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (15) @(posedge clk_Delay);
    #1;
    hold_in = 1'b0;
    repeat (30) @(negedge clk_Delay);
    check("highrst_no_valid", vcnt - base, 0);
    check("highrst_no_busy", 32'(busy_seen), 0);

    repeat (10) @(negedge clk_Delay);
    base = vcnt;
    busy_seen = 1'b0;
    pulse(3, 8'd0);
    wait_valid(base + 1, 30);
`ifdef HOLD_METER_GLITCH_FILTER_EN
    check("glitch_no_valid", vcnt - base, 0);
    check("glitch_no_busy", 32'(busy_seen), 0);
`else
    check("glitch_count", vcnt - base, 1);
    check("glitch_sec", 32'(log_sec[$]), 0);
    check("glitch_mis", 32'(log_mis[$]), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
